// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcode constants, immediate-format bit indices and the decoded-field bundle.
package rv_pkg;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Bit positions inside the one-hot immediate-format code shared with imm_gen.
    localparam int IMM_I = 4;
    localparam int IMM_S = 3;
    localparam int IMM_B = 2;
    localparam int IMM_J = 1;
    localparam int IMM_U = 0;

    typedef struct packed {
        logic [4:0] typ;
        logic       illegal;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [6:0] opcode;
    } id_fields_t;
endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: combinational opcode classification into a one-hot immediate format plus field slicing.
//   inst_i     instruction word
//   type_o     one-hot format {I,S,B,J,U}, zero for R-type or illegal
//   illegal_o  opcode outside the RV32I base set
//   rs1_o, rs2_o, rd_o, funct3_o, funct7_o, opcode_o  raw instruction fields
module inst_decoder
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] inst_i,
    output logic [4:0]      type_o,
    output logic            illegal_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [6:0]      opcode_o
);
    assign opcode_o = inst_i[6:0];
    assign rd_o     = inst_i[11:7];
    assign funct3_o = inst_i[14:12];
    assign rs1_o    = inst_i[19:15];
    assign rs2_o    = inst_i[24:20];
    assign funct7_o = inst_i[31:25];

    // Full 7-bit compare also rejects compressed encodings (inst[1:0] != 2'b11).
    always_comb begin
        type_o    = '0;
        illegal_o = 1'b0;
        case (inst_i[6:0])
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: type_o[IMM_I] = 1'b1;
            OPC_STORE:            type_o[IMM_S] = 1'b1;
            OPC_BRANCH:           type_o[IMM_B] = 1'b1;
            OPC_JAL:              type_o[IMM_J] = 1'b1;
            OPC_LUI, OPC_AUIPC:   type_o[IMM_U] = 1'b1;
            OPC_OP:               illegal_o = 1'b0;
            default:              illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID pipeline register with valid/ready handshake, flush and registered decode.
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i/ready_o     upstream handshake carrying inst_i, pc_i
//   flush_i             drop held and incoming instruction
//   valid_o/ready_i     downstream handshake
//   inst_o, pc_o        registered instruction and PC
//   type_o, illegal_o   registered format code and illegal flag
//   rs1_o, rs2_o, rd_o, funct3_o, funct7_o, opcode_o  registered fields
module id_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      type_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [6:0]      opcode_o,
    output logic            illegal_o
);
    id_fields_t      dec, fields_q;
    logic [XLEN-1:0] inst_q, pc_q;
    logic            valid_q, valid_d, load;

    inst_decoder #(.XLEN(XLEN)) u_dec (
        .inst_i   (inst_i),
        .type_o   (dec.typ),
        .illegal_o(dec.illegal),
        .rs1_o    (dec.rs1),
        .rs2_o    (dec.rs2),
        .rd_o     (dec.rd),
        .funct3_o (dec.funct3),
        .funct7_o (dec.funct7),
        .opcode_o (dec.opcode)
    );

    // A full stage still accepts when downstream drains in the same cycle.
    assign ready_o = ~valid_q | ready_i;
    assign load    = valid_i & ready_o & ~flush_i;
    assign valid_d = flush_i ? 1'b0 : load ? 1'b1 : ready_i ? 1'b0 : valid_q;

    // Data registers only move on a real load, so a stall keeps outputs bit-stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            inst_q   <= '0;
            pc_q     <= '0;
            fields_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                inst_q   <= inst_i;
                pc_q     <= pc_i;
                fields_q <= dec;
            end
        end
    end

    assign valid_o   = valid_q;
    assign inst_o    = inst_q;
    assign pc_o      = pc_q;
    assign type_o    = fields_q.typ;
    assign illegal_o = fields_q.illegal;
    assign rs1_o     = fields_q.rs1;
    assign rs2_o     = fields_q.rs2;
    assign rd_o      = fields_q.rd;
    assign funct3_o  = fields_q.funct3;
    assign funct7_o  = fields_q.funct7;
    assign opcode_o  = fields_q.opcode;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage with directed handshake, flush and reset cases.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_i, valid_i, flush_i, ready_i;
    logic [31:0] inst_i, pc_i;
    logic        ready_o, valid_o, illegal_o;
    logic [31:0] inst_o, pc_o;
    logic [4:0]  type_o, rs1_o, rs2_o, rd_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o, opcode_o;
    int          total = 0;
    int          bad = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  typ;
        logic        ill;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    id_stage #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .inst_o(inst_o), .pc_o(pc_o), .type_o(type_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o),
        .funct7_o(funct7_o), .opcode_o(opcode_o), .illegal_o(illegal_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] model(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h03 || op == 7'h0F || op == 7'h13 || op == 7'h67 || op == 7'h73) return 6'b10000_0;
        if (op == 7'h23) return 6'b01000_0;
        if (op == 7'h63) return 6'b00100_0;
        if (op == 7'h6F) return 6'b00010_0;
        if (op == 7'h37 || op == 7'h17) return 6'b00001_0;
        if (op == 7'h33) return 6'b00000_0;
        return 6'b00000_1;
    endfunction

    // Compare the head entry whenever the stage holds something; retire it on drain or flush.
    always @(negedge clk or posedge rst_i) begin
        if (rst_i) begin
            q.delete();
        end else begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 64'(valid_o), 64'd0);
                end else begin
                    chk("sb_inst", 64'(inst_o), 64'(q[0].inst));
                    chk("sb_pc", 64'(pc_o), 64'(q[0].pc));
                    chk("sb_type", 64'(type_o), 64'(q[0].typ));
                    chk("sb_illegal", 64'(illegal_o), 64'(q[0].ill));
                    chk("sb_fields", 64'({funct7_o, rs2_o, rs1_o, funct3_o, rd_o, opcode_o}), 64'(q[0].inst));
                    if (ready_i || flush_i) void'(q.pop_front());
                end
            end
            if (valid_i && ready_o && !flush_i)
                q.push_back({inst_i, pc_i, model(inst_i)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p);
        valid_i = v;
        inst_i  = w;
        pc_i    = p;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops[12];
        logic [31:0] w;
        ops = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h5B};
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; inst_i = '0; pc_i = '0;
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_type", 64'(type_o), 64'd0);
        chk("rst_illegal", 64'(illegal_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_inst", 64'(inst_o), 64'd0);
        step();
        rst_i = 1'b0;

        // addi x1,x2,5
        drive(1'b1, 32'h00510093, 32'h100);
        step();
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("addi_valid", 64'(valid_o), 64'd1);
        chk("addi_type", 64'(type_o), 64'b10000);
        chk("addi_rd", 64'(rd_o), 64'd1);
        chk("addi_rs1", 64'(rs1_o), 64'd2);
        chk("addi_illegal", 64'(illegal_o), 64'd0);

        // sw then add back-to-back
        step();
        drive(1'b1, 32'h00512423, 32'h104);
        step();
        drive(1'b1, 32'h003100B3, 32'h108);
        @(negedge clk);
        chk("sw_valid", 64'(valid_o), 64'd1);
        chk("sw_type", 64'(type_o), 64'b01000);
        chk("sw_rs2", 64'(rs2_o), 64'd5);
        step();
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("add_valid", 64'(valid_o), 64'd1);
        chk("add_type", 64'(type_o), 64'b00000);
        chk("add_rs2", 64'(rs2_o), 64'd3);
        chk("add_illegal", 64'(illegal_o), 64'd0);

        // stall: fill with auipc, then offer lui against backpressure
        step();
        ready_i = 1'b0;
        drive(1'b1, 32'h00001097, 32'h200);
        step();
        drive(1'b1, 32'h123450B7, 32'h204);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", 64'(ready_o), 64'd0);
            chk("stall_inst", 64'(inst_o), 64'h00001097);
            chk("stall_type", 64'(type_o), 64'b00001);
            step();
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk("unstall_ready", 64'(ready_o), 64'd1);
        step();
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("lui_inst", 64'(inst_o), 64'h123450B7);
        chk("lui_type", 64'(type_o), 64'b00001);

        // flush together with a JAL beat
        step();
        drive(1'b1, 32'h0080006F, 32'h300);
        flush_i = 1'b1;
        step();
        drive(1'b0, '0, '0);
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_jal_valid", 64'(valid_o), 64'd0);

        // flush of a held instruction under backpressure
        step();
        ready_i = 1'b0;
        drive(1'b1, 32'h003100B3, 32'h304);
        step();
        drive(1'b0, '0, '0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_held_valid", 64'(valid_o), 64'd0);
        chk("flush_held_ready", 64'(ready_o), 64'd1);
        ready_i = 1'b1;

        // illegal encodings
        step();
        drive(1'b1, 32'hFFFFFFFF, 32'h400);
        step();
        drive(1'b1, 32'h00000000, 32'h404);
        @(negedge clk);
        chk("ones_illegal", 64'(illegal_o), 64'd1);
        chk("ones_type", 64'(type_o), 64'd0);
        step();
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("zero_illegal", 64'(illegal_o), 64'd1);
        chk("zero_type", 64'(type_o), 64'd0);

        // random traffic with random backpressure and occasional flush
        for (int i = 0; i < 200; i++) begin
            step();
            w = $urandom;
            w[6:0] = ($urandom_range(0, 7) == 0) ? w[6:0] : ops[$urandom_range(0, 11)];
            drive(1'($urandom_range(0, 3) != 0), w, $urandom);
            ready_i = 1'($urandom_range(0, 2) != 0);
            flush_i = 1'($urandom_range(0, 15) == 0);
        end
        step();
        drive(1'b0, '0, '0);
        flush_i = 1'b0;
        ready_i = 1'b1;

        // asynchronous reset while holding an instruction
        step();
        ready_i = 1'b0;
        drive(1'b1, 32'h00510093, 32'h500);
        step();
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("prerst_valid", 64'(valid_o), 64'd1);
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_type", 64'(type_o), 64'd0);
        chk("arst_ready", 64'(ready_o), 64'd1);
        step();
        rst_i = 1'b0;
        ready_i = 1'b1;

        step();
        step();
        @(negedge clk);
        chk("sb_drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
